// File: rtl/mem_port_arbiter.sv
// Single memory port shared between instruction fetch (I) and data (D) requesters.
// One transaction at a time: grant in IDLE, present in REQ, collect a read in RESP.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_resp_valid,
  output logic [DATA_W-1:0] i_resp_rdata,
  input  logic              i_kill,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic              d_req_wen,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [DATA_W-1:0] d_req_wdata,
  input  logic [DATA_W-1:0] d_req_wmask,
  output logic              d_resp_valid,
  output logic [DATA_W-1:0] d_resp_rdata,
  output logic              m_req_valid,
  input  logic              m_req_ready,
  output logic              m_req_wen,
  output logic [ADDR_W-1:0] m_req_addr,
  output logic [DATA_W-1:0] m_req_wdata,
  output logic [DATA_W-1:0] m_req_wmask,
  input  logic              m_resp_valid,
  input  logic [DATA_W-1:0] m_resp_rdata,
  output logic              busy
);

  // Handshakes: a request transfers in the cycle where valid && ready are both
  // high; valid, once raised, is held with stable fields until ready. Responses
  // are single-cycle valid pulses with no back-pressure.

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  typedef enum logic {OWN_D, OWN_I} owner_t;

  state_t            state, state_nxt;
  owner_t            owner, owner_nxt;
  logic              lat_wen, lat_wen_nxt;
  logic [ADDR_W-1:0] lat_addr, lat_addr_nxt;
  logic [DATA_W-1:0] lat_wdata, lat_wdata_nxt;
  logic [DATA_W-1:0] lat_wmask, lat_wmask_nxt;
  logic [CNT_W-1:0]  starve_cnt, starve_cnt_nxt;
  logic              killed, killed_nxt;
  logic              grant_d, grant_i;

  // D wins unless I has already watched STARVE_LIMIT consecutive D grants.
  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (state == IDLE) begin
      if (d_req_valid && (!i_req_valid || (starve_cnt < LIMIT))) begin
        grant_d = 1'b1;
      end else if (i_req_valid && !i_kill) begin
        grant_i = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    lat_wen_nxt    = lat_wen;
    lat_addr_nxt   = lat_addr;
    lat_wdata_nxt  = lat_wdata;
    lat_wmask_nxt  = lat_wmask;
    starve_cnt_nxt = starve_cnt;
    killed_nxt     = killed;
    unique case (state)
      IDLE: begin
        if (grant_d) begin
          owner_nxt     = OWN_D;
          lat_wen_nxt   = d_req_wen;
          lat_addr_nxt  = d_req_addr;
          lat_wdata_nxt = d_req_wdata;
          lat_wmask_nxt = d_req_wmask;
          killed_nxt    = 1'b0;
          state_nxt     = REQ;
        end else if (grant_i) begin
          owner_nxt     = OWN_I;
          lat_wen_nxt   = 1'b0;
          lat_addr_nxt  = i_req_addr;
          lat_wdata_nxt = '0;
          lat_wmask_nxt = '0;
          killed_nxt    = 1'b0;
          state_nxt     = REQ;
        end
        if (grant_i || !i_req_valid) begin
          starve_cnt_nxt = '0;
        end else if (grant_d && (starve_cnt != LIMIT)) begin
          starve_cnt_nxt = starve_cnt + CNT_W'(1);
        end
      end
      REQ: begin
        if ((owner == OWN_I) && i_kill) killed_nxt = 1'b1;
        if (m_req_ready) state_nxt = lat_wen ? IDLE : RESP;
      end
      RESP: begin
        if ((owner == OWN_I) && i_kill) killed_nxt = 1'b1;
        if (m_resp_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= OWN_D;
      lat_wen    <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_wmask  <= '0;
      starve_cnt <= '0;
      killed     <= 1'b0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      lat_wen    <= lat_wen_nxt;
      lat_addr   <= lat_addr_nxt;
      lat_wdata  <= lat_wdata_nxt;
      lat_wmask  <= lat_wmask_nxt;
      starve_cnt <= starve_cnt_nxt;
      killed     <= killed_nxt;
    end
  end

  // Every output is a function of state, so reset forces all of them to 0.
  always_comb begin
    busy         = (state != IDLE);
    m_req_valid  = 1'b0;
    m_req_wen    = 1'b0;
    m_req_addr   = '0;
    m_req_wdata  = '0;
    m_req_wmask  = '0;
    i_req_ready  = 1'b0;
    d_req_ready  = 1'b0;
    i_resp_valid = 1'b0;
    i_resp_rdata = '0;
    d_resp_valid = 1'b0;
    d_resp_rdata = '0;
    if (state == REQ) begin
      m_req_valid = 1'b1;
      m_req_wen   = lat_wen;
      m_req_addr  = lat_addr;
      m_req_wdata = lat_wdata;
      m_req_wmask = lat_wmask;
      i_req_ready = m_req_ready && (owner == OWN_I);
      d_req_ready = m_req_ready && (owner == OWN_D);
    end
    if ((state == RESP) && m_resp_valid) begin
      if (owner == OWN_D) begin
        d_resp_valid = 1'b1;
        d_resp_rdata = m_resp_rdata;
      end else if (!killed && !i_kill) begin
        i_resp_valid = 1'b1;
        i_resp_rdata = m_resp_rdata;
      end
    end
  end

  // A presented memory request is never retracted or altered before acceptance.
  a_req_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (m_req_valid && !m_req_ready) |=> (m_req_valid && $stable(m_req_addr) && $stable(m_req_wen)));

  a_one_ready: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_req_ready && d_req_ready));

  a_starve_cap: assert property (@(posedge clk) disable iff (!rst_n)
    starve_cnt <= LIMIT);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector tables, directed corner sequences and a
// random run, all checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int LIMIT = 4;

  typedef struct {
    logic          i_valid;
    logic [AW-1:0] i_addr;
    logic          i_kill;
    logic          d_valid;
    logic          d_wen;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_wmask;
    logic          m_ready;
    logic          m_resp_valid;
    logic [DW-1:0] m_rdata;
  } in_t;

  typedef struct {
    logic          busy;
    logic          m_valid;
    logic          m_wen;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_wmask;
    logic          i_ready;
    logic          d_ready;
    logic          i_resp;
    logic          d_resp;
    logic [DW-1:0] i_rdata;
    logic [DW-1:0] d_rdata;
  } outs_t;

  typedef struct {
    in_t   in;
    outs_t exp;
  } vec_t;

  // Model: the one transaction currently owning the port, if any.
  typedef struct {
    bit            act;
    bit            is_i;
    bit            wen;
    bit            in_resp;
    bit            killed;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] wmask;
  } mtxn_t;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_req_valid, i_req_ready, i_resp_valid, i_kill;
  logic [AW-1:0] i_req_addr;
  logic [DW-1:0] i_resp_rdata;
  logic          d_req_valid, d_req_ready, d_req_wen, d_resp_valid;
  logic [AW-1:0] d_req_addr;
  logic [DW-1:0] d_req_wdata, d_req_wmask, d_resp_rdata;
  logic          m_req_valid, m_req_ready, m_req_wen, m_resp_valid, busy;
  logic [AW-1:0] m_req_addr;
  logic [DW-1:0] m_req_wdata, m_req_wmask, m_resp_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_resp_valid(i_resp_valid), .i_resp_rdata(i_resp_rdata), .i_kill(i_kill),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_wen(d_req_wen),
    .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata), .d_req_wmask(d_req_wmask),
    .d_resp_valid(d_resp_valid), .d_resp_rdata(d_resp_rdata),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_wen(m_req_wen),
    .m_req_addr(m_req_addr), .m_req_wdata(m_req_wdata), .m_req_wmask(m_req_wmask),
    .m_resp_valid(m_resp_valid), .m_resp_rdata(m_resp_rdata), .busy(busy)
  );

  int    checks = 0;
  int    failures = 0;
  mtxn_t mt;
  int    m_streak;

  // ---------------- helpers ----------------
  function automatic in_t idle_in();
    in_t v;
    v.i_valid = 0; v.i_addr = '0; v.i_kill = 0;
    v.d_valid = 0; v.d_wen = 0; v.d_addr = '0; v.d_wdata = '0; v.d_wmask = '0;
    v.m_ready = 0; v.m_resp_valid = 0; v.m_rdata = '0;
    return v;
  endfunction

  function automatic outs_t zero_outs();
    outs_t e;
    e.busy = 0; e.m_valid = 0; e.m_wen = 0; e.m_addr = '0; e.m_wdata = '0; e.m_wmask = '0;
    e.i_ready = 0; e.d_ready = 0; e.i_resp = 0; e.d_resp = 0; e.i_rdata = '0; e.d_rdata = '0;
    return e;
  endfunction

  task automatic drive(input in_t v);
    i_req_valid = v.i_valid; i_req_addr = v.i_addr; i_kill = v.i_kill;
    d_req_valid = v.d_valid; d_req_wen = v.d_wen; d_req_addr = v.d_addr;
    d_req_wdata = v.d_wdata; d_req_wmask = v.d_wmask;
    m_req_ready = v.m_ready; m_resp_valid = v.m_resp_valid; m_resp_rdata = v.m_rdata;
  endtask

  task automatic sample(output outs_t a);
    a.busy = busy; a.m_valid = m_req_valid; a.m_wen = m_req_wen; a.m_addr = m_req_addr;
    a.m_wdata = m_req_wdata; a.m_wmask = m_req_wmask;
    a.i_ready = i_req_ready; a.d_ready = d_req_ready;
    a.i_resp = i_resp_valid; a.d_resp = d_resp_valid;
    a.i_rdata = i_resp_rdata; a.d_rdata = d_resp_rdata;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cmp_outs(input string tag, input outs_t a, input outs_t e);
    chk({tag, ".busy"},    64'(a.busy),    64'(e.busy));
    chk({tag, ".m_valid"}, 64'(a.m_valid), 64'(e.m_valid));
    chk({tag, ".m_wen"},   64'(a.m_wen),   64'(e.m_wen));
    chk({tag, ".m_addr"},  64'(a.m_addr),  64'(e.m_addr));
    chk({tag, ".m_wdata"}, 64'(a.m_wdata), 64'(e.m_wdata));
    chk({tag, ".m_wmask"}, 64'(a.m_wmask), 64'(e.m_wmask));
    chk({tag, ".i_ready"}, 64'(a.i_ready), 64'(e.i_ready));
    chk({tag, ".d_ready"}, 64'(a.d_ready), 64'(e.d_ready));
    chk({tag, ".i_resp"},  64'(a.i_resp),  64'(e.i_resp));
    chk({tag, ".d_resp"},  64'(a.d_resp),  64'(e.d_resp));
    chk({tag, ".i_rdata"}, 64'(a.i_rdata), 64'(e.i_rdata));
    chk({tag, ".d_rdata"}, 64'(a.d_rdata), 64'(e.d_rdata));
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    mt = '{default: 0};
    m_streak = 0;
  endtask

  function automatic outs_t model_outs(input in_t v);
    outs_t e = zero_outs();
    if (mt.act) begin
      e.busy = 1;
      if (!mt.in_resp) begin
        e.m_valid = 1; e.m_wen = mt.wen; e.m_addr = mt.addr;
        e.m_wdata = mt.wdata; e.m_wmask = mt.wmask;
        if (mt.is_i) e.i_ready = v.m_ready;
        else         e.d_ready = v.m_ready;
      end else if (v.m_resp_valid) begin
        if (!mt.is_i) begin
          e.d_resp = 1; e.d_rdata = v.m_rdata;
        end else if (!(mt.killed || v.i_kill)) begin
          e.i_resp = 1; e.i_rdata = v.m_rdata;
        end
      end
    end
    return e;
  endfunction

  task automatic model_next(input in_t v);
    bit give_d, give_i;
    if (!mt.act) begin
      give_d = v.d_valid && (!v.i_valid || m_streak < LIMIT);
      give_i = !give_d && v.i_valid && !v.i_kill;
      if (give_d || give_i) begin
        mt.act = 1; mt.in_resp = 0; mt.killed = 0; mt.is_i = give_i;
        mt.wen   = give_d ? v.d_wen : 1'b0;
        mt.addr  = give_d ? v.d_addr : v.i_addr;
        mt.wdata = give_d ? v.d_wdata : '0;
        mt.wmask = give_d ? v.d_wmask : '0;
      end
      if (give_i || !v.i_valid) m_streak = 0;
      else if (give_d && m_streak < LIMIT) m_streak++;
    end else begin
      if (mt.is_i && v.i_kill) mt.killed = 1;
      if (!mt.in_resp) begin
        if (v.m_ready) begin
          if (mt.wen) mt.act = 0;
          else        mt.in_resp = 1;
        end
      end else if (v.m_resp_valid) begin
        mt.act = 0;
      end
    end
  endtask

  // One clock: drive at negedge, compare 1 ns later, then advance the model.
  task automatic step(input in_t v, input string tag, output outs_t a);
    outs_t e;
    @(negedge clk);
    drive(v);
    #1;
    sample(a);
    e = model_outs(v);
    cmp_outs({tag, "/model"}, a, e);
    model_next(v);
  endtask

  // ---------------- test ----------------
  vec_t        tbl[$];
  logic [0:0]  exp_q[$];
  logic [0:0]  obs_q[$];

  initial begin
    in_t   v;
    outs_t e, a;
    bit    i_pend, d_pend;

    rst_n = 1'b0;
    drive(idle_in());
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    sample(a);
    cmp_outs("reset", a, zero_outs());
    chk("reset.starve_cnt", 64'(dut.starve_cnt), 64'(0));
    rst_n = 1'b1;

    // Table 1: lone D store, memory always ready.
    v = idle_in(); v.d_valid = 1; v.d_wen = 1; v.d_addr = 32'h100;
    v.d_wdata = 32'hDEADBEEF; v.d_wmask = 32'hFF; v.m_ready = 1;
    e = zero_outs();
    tbl.push_back('{v, e});
    e.busy = 1; e.m_valid = 1; e.m_wen = 1; e.m_addr = 32'h100;
    e.m_wdata = 32'hDEADBEEF; e.m_wmask = 32'hFF; e.d_ready = 1;
    tbl.push_back('{v, e});
    v = idle_in(); v.m_ready = 1; e = zero_outs();
    tbl.push_back('{v, e});
    tbl.push_back('{v, e});
    // Table 2: lone I read, data two cycles after acceptance; stray m_resp_valid ignored.
    v = idle_in(); v.i_valid = 1; v.i_addr = 32'h8000_0000; v.m_resp_valid = 1; v.m_rdata = 32'hBAD;
    e = zero_outs();
    tbl.push_back('{v, e});
    v.m_ready = 1;
    e.busy = 1; e.m_valid = 1; e.m_addr = 32'h8000_0000; e.i_ready = 1;
    tbl.push_back('{v, e});
    v = idle_in(); e = zero_outs(); e.busy = 1;
    tbl.push_back('{v, e});
    v.m_resp_valid = 1; v.m_rdata = 32'h13;
    e.i_resp = 1; e.i_rdata = 32'h13;
    tbl.push_back('{v, e});
    v = idle_in(); e = zero_outs();
    tbl.push_back('{v, e});

    foreach (tbl[k]) begin
      step(tbl[k].in, $sformatf("tbl%0d", k), a);
      cmp_outs($sformatf("tbl%0d", k), a, tbl[k].exp);
    end

    // Starvation: both sides hold loads continuously, zero-wait memory.
    exp_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    v = idle_in(); v.i_valid = 1; v.i_addr = 32'h4000; v.d_valid = 1; v.d_addr = 32'h2000;
    v.m_ready = 1; v.m_resp_valid = 1;
    for (int c = 0; c < 30; c++) begin
      v.m_rdata = 32'(c);
      step(v, "starve", a);
      if (a.d_ready) obs_q.push_back(1'b0);
      if (a.i_ready) obs_q.push_back(1'b1);
      chk("starve.cnt_le_limit", 64'(dut.starve_cnt <= 3'(LIMIT)), 64'(1));
    end
    chk("starve.grant_count", 64'(obs_q.size()), 64'(exp_q.size()));
    foreach (exp_q[k]) begin
      if (k < obs_q.size()) chk($sformatf("starve.grant%0d_is_i", k), 64'(obs_q[k]), 64'(exp_q[k]));
    end
    v = idle_in();
    step(v, "starve_drain", a);
    chk("starve_drain.busy", 64'(a.busy), 64'(0));

    // Kill: I read killed in REQ still completes on the memory side, data dropped.
    v = idle_in(); v.i_valid = 1; v.i_addr = 32'h8000_0040;
    step(v, "kill_grant", a);
    v.i_kill = 1;
    step(v, "kill_req0", a);
    chk("kill.m_valid_held", 64'(a.m_valid), 64'(1));
    v.i_kill = 0;
    step(v, "kill_req1", a);
    chk("kill.m_valid_held2", 64'(a.m_valid), 64'(1));
    v.m_ready = 1;
    step(v, "kill_accept", a);
    chk("kill.i_ready", 64'(a.i_ready), 64'(1));
    v = idle_in(); v.m_resp_valid = 1; v.m_rdata = 32'h55AA;
    step(v, "kill_resp", a);
    chk("kill.i_resp_dropped", 64'(a.i_resp), 64'(0));
    v = idle_in(); v.d_valid = 1; v.d_addr = 32'h200; v.m_ready = 1;
    step(v, "kill_dgrant", a);
    step(v, "kill_dreq", a);
    chk("kill.d_ready", 64'(a.d_ready), 64'(1));
    chk("kill.d_addr", 64'(a.m_addr), 64'(32'h200));
    v = idle_in(); v.m_resp_valid = 1; v.m_rdata = 32'h1234;
    step(v, "kill_dresp", a);
    chk("kill.d_resp", 64'(a.d_resp), 64'(1));
    chk("kill.d_rdata", 64'(a.d_rdata), 64'(32'h1234));

    // Stall: memory holds ready low for 5 REQ cycles.
    v = idle_in(); v.d_valid = 1; v.d_wen = 1; v.d_addr = 32'h300;
    v.d_wdata = 32'hCAFE0001; v.d_wmask = 32'hF0F0;
    step(v, "stall_grant", a);
    for (int c = 0; c < 5; c++) begin
      step(v, "stall", a);
      chk("stall.m_valid", 64'(a.m_valid), 64'(1));
      chk("stall.m_addr", 64'(a.m_addr), 64'(32'h300));
      chk("stall.m_wdata", 64'(a.m_wdata), 64'(32'hCAFE0001));
      chk("stall.m_wmask", 64'(a.m_wmask), 64'(32'hF0F0));
      chk("stall.d_ready", 64'(a.d_ready), 64'(0));
    end
    v.m_ready = 1;
    step(v, "stall_accept", a);
    chk("stall.d_ready_rise", 64'(a.d_ready), 64'(1));
    v = idle_in();
    step(v, "stall_idle", a);

    // Random traffic obeying the hold-until-ready contract.
    i_pend = 0; d_pend = 0; v = idle_in();
    for (int c = 0; c < 1500; c++) begin
      if (!i_pend && $urandom_range(0, 2) == 0) begin
        i_pend = 1; v.i_addr = $urandom;
      end
      if (!d_pend && $urandom_range(0, 2) == 0) begin
        d_pend = 1; v.d_wen = 1'($urandom_range(0, 1)); v.d_addr = $urandom;
        v.d_wdata = $urandom; v.d_wmask = $urandom;
      end
      v.i_valid = i_pend;
      v.d_valid = d_pend;
      v.i_kill = ($urandom_range(0, 9) == 0);
      v.m_ready = ($urandom_range(0, 3) != 0);
      v.m_resp_valid = ($urandom_range(0, 2) == 0);
      v.m_rdata = $urandom;
      step(v, "rnd", a);
      if (a.i_ready) i_pend = 0;
      if (a.d_ready) d_pend = 0;
    end
    v = idle_in(); v.m_ready = 1; v.m_resp_valid = 1;
    repeat (3) step(v, "rnd_drain", a);

    // Asynchronous reset while a load waits in RESP.
    v = idle_in(); v.d_valid = 1; v.d_addr = 32'h400; v.m_ready = 1;
    step(v, "rst_grant", a);
    step(v, "rst_req", a);
    v = idle_in();
    step(v, "rst_wait", a);
    chk("rst.in_resp_busy", 64'(a.busy), 64'(1));
    @(negedge clk);
    v = idle_in(); v.m_resp_valid = 1; v.m_rdata = 32'h77; v.d_valid = 1; v.m_ready = 1;
    drive(v);
    #1;
    sample(a);
    chk("rst.pre_d_resp", 64'(a.d_resp), 64'(1));
    rst_n = 1'b0;
    #1;
    sample(a);
    cmp_outs("rst_async", a, zero_outs());
    model_reset();
    v.d_valid = 0;
    drive(v);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step(v, "rst_after", a);
      cmp_outs("rst_after", a, zero_outs());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory port between instruction fetch (I side) and the memory stage's data requests (D side).
- Data requests use the DRequest/DResponse fields (valid, ready, wen, addr, wdata, wmask / valid, rdata).
- Sequences one transaction at a time: latch the winner's request, present it to memory, wait for ready, then route any read response back to the owner.
- Data has priority, but a starvation counter guarantees that fetch makes progress. Instruction responses can be killed on pipeline flush.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data / wmask width
STARVE_LIMIT, 4, max consecutive D grants while I is waiting; must be >= 1

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_req_valid  in  1  fetch request valid
i_req_ready  out  1  fetch request accepted by memory this cycle
i_req_addr  in  ADDR_W  fetch address
i_resp_valid  out  1  fetch read data valid
i_resp_rdata  out  DATA_W  fetch read data
i_kill  in  1  discard the in-flight or pending fetch response (pipeline_flush)
d_req_valid  in  1  data request valid
d_req_ready  out  1  data request accepted by memory this cycle
d_req_wen  in  1  1 = store, 0 = load
d_req_addr  in  ADDR_W  data address
d_req_wdata  in  DATA_W  store data
d_req_wmask  in  DATA_W  store byte mask
d_resp_valid  out  1  load data valid
d_resp_rdata  out  DATA_W  load data
m_req_valid  out  1  memory request valid
m_req_ready  in  1  memory accepts request
m_req_wen  out  1  memory write enable
m_req_addr  out  ADDR_W  memory address
m_req_wdata  out  DATA_W  memory write data
m_req_wmask  out  DATA_W  memory write mask
m_resp_valid  in  1  memory read data valid
m_resp_rdata  in  DATA_W  memory read data
busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, owner=D, all latched request fields 0, starve_cnt=0, killed=0. All outputs are 0 while in reset.
- States: IDLE, REQ, RESP.
- IDLE, arbitration:
  - If the only requester is D, or both request and starve_cnt<STARVE_LIMIT: owner=D.
  - Otherwise, if i_req_valid && !i_kill: owner=I.
  - A requester is granted only if its valid is high. On a grant, latch wen/addr/wdata/wmask (I side: wen=0, wdata=0, wmask=0), clear killed, and go to REQ.
  - With no valid request, stay in IDLE.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) on a D grant when i_req_valid is also high.
  - Clears on an I grant, or in IDLE when i_req_valid is low.
- REQ:
  - m_req_valid=1 with the latched fields.
  - Once asserted, m_req_valid stays high until m_req_ready; it is never retracted, even on i_kill.
  - On m_req_ready, the owner's *_req_ready=1 for that cycle (combinational from m_req_ready).
  - Next state: a write goes to IDLE; a read goes to RESP.
- RESP:
  - m_req_valid=0.
  - On m_resp_valid, route m_resp_rdata to the owner: *_resp_valid=1 the same cycle, combinationally. Then go to IDLE.
  - If owner=I and (killed || i_kill), i_resp_valid stays 0 and the data is dropped; the state still returns to IDLE.
- killed: set when i_kill is high while owner=I in REQ or RESP. Cleared on the next grant.
- Requester contract: hold valid and fields stable until *_req_ready. Requests are latched at grant, so changes after grant are ignored.
- Latency:
  - Request reaches m_req_* 1 cycle after the grant cycle.
  - Minimum transaction is 2 cycles (IDLE, REQ) for a write and 3 cycles for a read with zero-wait memory.
  - Every transaction ends with one IDLE cycle before the next grant.
- *_resp_rdata equals m_resp_rdata whenever the corresponding valid is high; otherwise it is 0.
- m_resp_valid outside RESP is ignored.
- A non-owner never sees *_req_ready or *_resp_valid.

Test Plan:
- Only D store (addr 0x100, wdata 0xDEADBEEF, wmask 0xFF), m_req_ready tied 1 → m_req_valid 1 cycle after the grant with identical fields; d_req_ready pulses once; no d_resp_valid; busy returns to 0.
- Only I read (addr 0x8000_0000), memory returns 0x00000013 two cycles after ready → i_resp_valid=1 for exactly one cycle with rdata 0x00000013; d_resp_valid stays 0.
- I and D both held valid continuously with STARVE_LIMIT=4, loads only → grant order D,D,D,D,I,D,D,D,D,I; starve_cnt is never greater than 4.
- I read granted, i_kill pulsed in REQ before m_req_ready → memory still sees the request and it completes; response arrives; i_resp_valid stays 0; next D request is granted normally.
- m_req_ready held low 5 cycles → m_req_valid and fields remain stable for all 5 cycles; *_req_ready is 0 until ready rises.
- rst_n asserted in RESP with a response pending → state IDLE and all outputs 0 immediately (asynchronously); a later m_resp_valid is ignored; no resp_valid is produced.
